// File: rtl/alu8_seq_ctrl.sv
// Multi-byte sequencer: runs NBYTES-wide add/logic ops through one shared ALU8, LSB byte first.
// Latency: response NBYTES edges after accept for legal modes; illegal modes go straight to DONE.
// Backpressure: one request in flight; req_ready low until the response is taken, outputs held while stalled.
module alu8_seq_ctrl #(
  parameter int NBYTES = 4,
  parameter int W      = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_mode,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic         req_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_x,
  output logic         rsp_cout,
  output logic         rsp_err,
  output logic [2:0]   alu_mode,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic         alu_cin,
  input  logic [7:0]   alu_x,
  input  logic         alu_cout
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic [W-1:0]  r_res;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [2:0]    r_mode;
  logic [W-1:0]  r_rsp_x;
  logic          r_rsp_cout;
  logic          r_rsp_err;

  logic          w_run;
  logic          w_accept;
  logic          w_req_legal;
  logic          w_is_add;
  logic          w_carry_next;
  logic [IW+2:0] w_base;
  logic [W-1:0]  w_res_next;

  assign w_run        = (r_state == S_RUN);
  assign req_ready    = (r_state == S_IDLE);
  assign rsp_valid    = (r_state == S_DONE);
  assign w_accept     = req_valid && req_ready;
  assign w_req_legal  = (req_mode <= 3'd4);
  assign w_is_add     = (r_mode == 3'd0);
  assign w_carry_next = w_is_add ? alu_cout : 1'b0;
  assign w_base       = {r_idx, 3'b000};

  // ALU8 ports are only live in RUN so the shared ALU sees zeros otherwise
  assign alu_mode = w_run ? r_mode : 3'd0;
  assign alu_a    = w_run ? r_a[w_base +: 8] : 8'd0;
  assign alu_b    = w_run ? r_b[w_base +: 8] : 8'd0;
  assign alu_cin  = w_run ? r_carry : 1'b0;

  assign rsp_x    = r_rsp_x;
  assign rsp_cout = r_rsp_cout;
  assign rsp_err  = r_rsp_err;

  // Result with the current byte slot replaced by the ALU output
  always_comb begin
    w_res_next = r_res;
    w_res_next[w_base +: 8] = alu_x;
  end

  // Sequencer FSM, operand capture, byte stepping and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_res      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_mode     <= 3'd0;
      r_rsp_x    <= '0;
      r_rsp_cout <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= req_a;
            r_b     <= req_b;
            r_mode  <= req_mode;
            r_carry <= (req_mode == 3'd0) ? req_cin : 1'b0;
            r_idx   <= '0;
            r_res   <= '0;
            if (w_req_legal) begin
              r_state <= S_RUN;
            end else begin
              // Illegal mode never touches the ALU; respond with an error at once
              r_state    <= S_DONE;
              r_rsp_x    <= '0;
              r_rsp_cout <= 1'b0;
              r_rsp_err  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_res   <= w_res_next;
          r_carry <= w_carry_next;
          if (r_idx == LAST_IDX) begin
            // Last byte: publish the response; idx stops here so it never wraps
            r_state    <= S_DONE;
            r_rsp_x    <= w_res_next;
            r_rsp_cout <= w_carry_next;
            r_rsp_err  <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu8_seq_ctrl.sv
// Directed bench for alu8_seq_ctrl with a behavioural ALU8 attached to the alu_* ports.
// Latency: checks response timing in edges after the accepting edge.
// Backpressure: stalls rsp_ready in DONE and checks held outputs and req_ready gating.
module tb_alu8_seq_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_mode;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_cin;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_x;
  logic         rsp_cout;
  logic         rsp_err;
  logic [2:0]   alu_mode;
  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic         alu_cin;
  logic [7:0]   alu_x;
  logic         alu_cout;

  int checks;
  int errors;

  logic [7:0] rec_a   [0:39];
  logic       rec_cin [0:39];
  logic [2:0] rec_mode[0:39];
  int         lat;

  alu8_seq_ctrl #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
    .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_x(alu_x), .alu_cout(alu_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU8: combinational X and carry-out
  logic [8:0] m_sum;
  always_comb begin
    m_sum    = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
    alu_x    = 8'd0;
    alu_cout = 1'b0;
    case (alu_mode)
      3'd0: begin alu_x = m_sum[7:0]; alu_cout = m_sum[8]; end
      3'd1: alu_x = alu_a & alu_b;
      3'd2: alu_x = alu_a | alu_b;
      3'd3: alu_x = alu_a ^ alu_b;
      3'd4: alu_x = ~(alu_a ^ alu_b);
      default: alu_x = 8'd0;
    endcase
  end

  // Present one request, let it be accepted, then record ALU port activity until rsp_valid
  task automatic run_op(input logic [2:0] mode, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin);
    @(negedge clk);
    req_valid = 1'b1;
    req_mode  = mode;
    req_a     = a;
    req_b     = b;
    req_cin   = cin;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    // scramble request inputs after accept; they must be ignored
    req_valid = 1'b0;
    req_a     = ~a;
    req_b     = ~b;
    req_cin   = ~cin;
    req_mode  = 3'd2;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      rec_a[lat]    = alu_a;
      rec_cin[lat]  = alu_cin;
      rec_mode[lat] = alu_mode;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_x !== '0 || rsp_cout !== 1'b0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: ready=%b vld=%b x=%h cout=%b err=%b, want 1 0 0 0 0",
               req_ready, rsp_valid, rsp_x, rsp_cout, rsp_err);
    end
    checks++;
    if (alu_mode !== 3'd0 || alu_a !== 8'd0 || alu_b !== 8'd0 || alu_cin !== 1'b0) begin
      errors++;
      $display("FAIL reset_alu: mode=%h a=%h b=%h cin=%b, want all 0", alu_mode, alu_a, alu_b, alu_cin);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b vld=%b, want 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_add_carry();
    logic [3:0] cin_seq;
    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL add_carry_latency: got %0d edges, want 4", lat);
    end
    cin_seq = {rec_cin[3], rec_cin[2], rec_cin[1], rec_cin[0]};
    checks++;
    if (cin_seq !== 4'b1110) begin
      errors++;
      $display("FAIL add_carry_cin_seq: got %b (idx3..0), want 1110", cin_seq);
    end
    checks++;
    if (rsp_x !== 32'h0000_0000 || rsp_cout !== 1'b1 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL add_carry_rsp: x=%h cout=%b err=%b, want 00000000 1 0", rsp_x, rsp_cout, rsp_err);
    end
    take_rsp();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_cout !== 1'b1) begin
      errors++;
      $display("FAIL add_carry_handshake: vld=%b ready=%b cout=%b, want 0 1 1(held)", rsp_valid, req_ready, rsp_cout);
    end
  endtask

  task automatic test_add_cin();
    logic [31:0] a_seq;
    run_op(3'd0, 32'h1234_5678, 32'h1111_1111, 1'b1);
    a_seq = {rec_a[3], rec_a[2], rec_a[1], rec_a[0]};
    checks++;
    if (a_seq !== 32'h1234_5678 || lat !== 4) begin
      errors++;
      $display("FAIL add_cin_bytes: alu_a seq(idx3..0)=%h lat=%0d, want 12345678 4", a_seq, lat);
    end
    checks++;
    if (rsp_x !== 32'h2345_678A || rsp_cout !== 1'b0) begin
      errors++;
      $display("FAIL add_cin_rsp: x=%h cout=%b, want 2345678a 0", rsp_x, rsp_cout);
    end
    take_rsp();
  endtask

  task automatic test_xnor();
    run_op(3'd4, 32'hF0F0_AA55, 32'h0F0F_AA00, 1'b1);
    checks++;
    if (rsp_x !== 32'h0000_FFAA || rsp_cout !== 1'b0 || lat !== 4) begin
      errors++;
      $display("FAIL xnor_rsp: x=%h cout=%b lat=%0d, want 0000ffaa 0 4", rsp_x, rsp_cout, lat);
    end
    checks++;
    if ({rec_cin[0], rec_cin[1], rec_cin[2], rec_cin[3]} !== 4'b0000 ||
        rec_mode[0] !== 3'd4 || rec_mode[3] !== 3'd4) begin
      errors++;
      $display("FAIL xnor_alu_ports: cin=%b%b%b%b mode0=%h mode3=%h, want 0000 4 4",
               rec_cin[0], rec_cin[1], rec_cin[2], rec_cin[3], rec_mode[0], rec_mode[3]);
    end
    take_rsp();
  endtask

  task automatic test_illegal();
    run_op(3'd6, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    checks++;
    if (lat !== 0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL illegal_timing: rsp_valid after %0d extra edges ready=%b, want 0 0", lat, req_ready);
    end
    checks++;
    if (rsp_err !== 1'b1 || rsp_x !== '0 || rsp_cout !== 1'b0 || alu_mode !== 3'd0) begin
      errors++;
      $display("FAIL illegal_rsp: err=%b x=%h cout=%b alu_mode=%h, want 1 0 0 0", rsp_err, rsp_x, rsp_cout, alu_mode);
    end
    take_rsp();
  endtask

  task automatic test_back_to_back();
    int bad;
    run_op(3'd2, 32'h0000_00F0, 32'h0000_000F, 1'b0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b1 || rsp_x !== 32'h0000_00FF || req_ready !== 1'b0 || rsp_err !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold: %0d bad cycles (vld=%b x=%h ready=%b), want 0 (1 000000ff 0)",
               bad, rsp_valid, rsp_x, req_ready);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: vld=%b ready=%b, want 0 1", rsp_valid, req_ready);
    end
    run_op(3'd3, 32'hA5A5_A5A5, 32'hFFFF_0000, 1'b0);
    checks++;
    if (rsp_x !== 32'h5A5A_A5A5 || lat !== 4 || rsp_cout !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_xor: x=%h lat=%0d cout=%b, want 5a5aa5a5 4 0", rsp_x, lat, rsp_cout);
    end
    take_rsp();
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    req_valid = 1'b1;
    req_mode  = 3'd0;
    req_a     = 32'h0102_0304;
    req_b     = 32'h1010_1010;
    req_cin   = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checks++;
    if (alu_a !== 8'h02) begin
      errors++;
      $display("FAIL midrun_idx2: alu_a=%h, want 02", alu_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (alu_a !== 8'd0 || alu_b !== 8'd0 || alu_mode !== 3'd0 || rsp_valid !== 1'b0 ||
        req_ready !== 1'b1 || rsp_x !== '0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: a=%h b=%h mode=%h vld=%b ready=%b x=%h err=%b, want 0 0 0 0 1 0 0",
               alu_a, alu_b, alu_mode, rsp_valid, req_ready, rsp_x, rsp_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_release: ready=%b vld=%b, want 1 0", req_ready, rsp_valid);
    end
    run_op(3'd1, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1);
    checks++;
    if (rsp_x !== 32'h0F00_0F00 || rsp_cout !== 1'b0 || lat !== 4) begin
      errors++;
      $display("FAIL after_reset_and: x=%h cout=%b lat=%0d, want 0f000f00 0 4", rsp_x, rsp_cout, lat);
    end
    take_rsp();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_mode  = 3'd0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = 1'b0;
    rsp_ready = 1'b0;
    test_reset();
    test_add_carry();
    test_add_cin();
    test_xnor();
    test_illegal();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
